// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO pair: shift-add multiply,
// restoring divide, sign fix-up in a final cycle; MTHI/MTLO writes while idle.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             we_hi,
    input  logic             we_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [CW-1:0]      count_reg;
    logic               is_div_reg;
    logic               neg_q_reg;
    logic               neg_r_reg;
    logic [WIDTH-1:0]   a_raw_reg;
    logic [WIDTH-1:0]   operand_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0]   rem_reg;
    logic [WIDTH-1:0]   hi_reg, lo_reg;
    logic               busy_reg, done_reg, div_zero_reg;

    // Launch-time operand conditioning: magnitudes for signed ops
    logic               signed_op;
    logic [WIDTH-1:0]   a_mag, b_mag;

    assign signed_op = ~op[0];
    assign a_mag     = (signed_op && a[WIDTH-1]) ? -a : a;
    assign b_mag     = (signed_op && b[WIDTH-1]) ? -b : b;

    // One multiply iteration: conditional add of the multiplicand, then shift right
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;

    assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, operand_reg} : '0);
    assign mul_next = {mul_sum, acc_reg[WIDTH-1:1]};

    // One restoring-divide iteration; the dividend shifts out of acc_reg's low half
    // while quotient bits shift in behind it.
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     rem_diff;
    logic               rem_neg;

    assign rem_shift = {rem_reg, acc_reg[WIDTH-1]};
    assign rem_diff  = rem_shift - {1'b0, operand_reg};
    assign rem_neg   = rem_diff[WIDTH];

    logic [WIDTH-1:0]   quot_raw;
    logic [2*WIDTH-1:0] prod_fixed;

    assign quot_raw   = acc_reg[WIDTH-1:0];
    assign prod_fixed = neg_q_reg ? -acc_reg : acc_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (count_reg == CW'(WIDTH - 1)) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            div_zero_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            busy_reg     <= (state_next != IDLE);
            done_reg     <= (state_reg == FIX);
            div_zero_reg <= (state_reg == FIX) && is_div_reg && (operand_reg == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg   <= '0;
            is_div_reg  <= 1'b0;
            neg_q_reg   <= 1'b0;
            neg_r_reg   <= 1'b0;
            a_raw_reg   <= '0;
            operand_reg <= '0;
            acc_reg     <= '0;
            rem_reg     <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (we_hi) hi_reg <= wdata;
                    if (we_lo) lo_reg <= wdata;
                    if (start) begin
                        count_reg   <= '0;
                        is_div_reg  <= op[1];
                        neg_q_reg   <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r_reg   <= signed_op && a[WIDTH-1];
                        a_raw_reg   <= a;
                        operand_reg <= b_mag;
                        acc_reg     <= {{WIDTH{1'b0}}, a_mag};
                        rem_reg     <= '0;
                    end
                end
                CALC: begin
                    count_reg <= count_reg + 1'b1;
                    if (is_div_reg) begin
                        rem_reg <= rem_neg ? rem_shift[WIDTH-1:0] : rem_diff[WIDTH-1:0];
                        acc_reg <= {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-2:0], ~rem_neg};
                    end else begin
                        acc_reg <= mul_next;
                    end
                end
                FIX: begin
                    if (!is_div_reg) begin
                        hi_reg <= prod_fixed[2*WIDTH-1:WIDTH];
                        lo_reg <= prod_fixed[WIDTH-1:0];
                    end else if (operand_reg == '0) begin
                        // Divide by zero leaves the dividend in HI untouched by sign fix
                        hi_reg <= a_raw_reg;
                        lo_reg <= '1;
                    end else begin
                        hi_reg <= neg_r_reg ? -rem_reg : rem_reg;
                        lo_reg <= neg_q_reg ? -quot_raw : quot_raw;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign div_zero = div_zero_reg;
    assign hi       = hi_reg;
    assign lo       = lo_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, corner sequences
// and randomized operations against an arithmetic reference model.
module tb_mult_div_unit;

    localparam int WIDTH = 32;
    localparam int LAT   = WIDTH + 1;

    logic             clk;
    logic             rst;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a, b;
    logic             we_hi, we_lo;
    logic [WIDTH-1:0] wdata;
    logic             busy, done, div_zero;
    logic [WIDTH-1:0] hi, lo;

    int n_vec  = 0;
    int n_miss = 0;
    logic [31:0] mdl_hi, mdl_lo;

    mult_div_unit #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .we_hi(we_hi), .we_lo(we_lo), .wdata(wdata),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic        exp_dz;
    } vec_t;

    task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic, returns {div_zero, hi, lo}
    function automatic logic [64:0] ref_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy, q, r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            2'd0: begin
                q = sx * sy;
                return {1'b0, q[63:0]};
            end
            2'd1: begin
                p = {32'd0, x} * {32'd0, y};
                return {1'b0, p};
            end
            default: begin
                if (y == 32'd0) return {1'b1, x, 32'hFFFF_FFFF};
                if (o == 2'd2) begin
                    q = sx / sy;
                    r = sx % sy;
                    return {1'b0, r[31:0], q[31:0]};
                end
                return {1'b0, x % y, x / y};
            end
        endcase
    endfunction

    // Launch an op in IDLE and follow it to completion. intf_cycle>0 pulses a
    // conflicting start + HI/LO writes mid-operation; wr_both writes both
    // registers in the launch cycle.
    task automatic run_op(input logic [1:0] op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                          input int intf_cycle, input bit wr_both, input logic [31:0] wv, input string tag);
        logic [64:0] exp;
        exp   = ref_model(op_i, a_i, b_i);
        start = 1'b1; op = op_i; a = a_i; b = b_i;
        if (wr_both) begin we_hi = 1'b1; we_lo = 1'b1; wdata = wv; end
        @(posedge clk); #1;
        start = 1'b0; we_hi = 1'b0; we_lo = 1'b0;
        a = $urandom; b = $urandom; op = 2'($urandom);
        if (wr_both) begin mdl_hi = wv; mdl_lo = wv; end
        for (int k = 1; k <= LAT; k++) begin
            if (k < LAT) begin
                check({tag, "_calc_busy_done_hold"}, {busy, done, mdl_hi, mdl_lo}, {1'b1, 1'b0, mdl_hi, mdl_lo});
            end
            @(posedge clk); #1;
            if (k == intf_cycle) begin
                start = 1'b1; op = 2'd3; we_hi = 1'b1; we_lo = 1'b1; wdata = $urandom;
            end else begin
                start = 1'b0; we_hi = 1'b0; we_lo = 1'b0;
            end
        end
        check({tag, "_result"}, {busy, done, div_zero, hi, lo}, {1'b0, 1'b1, exp[64], exp[63:0]});
        start = 1'b0; we_hi = 1'b0; we_lo = 1'b0;
        mdl_hi = exp[63:32];
        mdl_lo = exp[31:0];
        @(posedge clk); #1;
        check({tag, "_done_clear"}, {busy, done, div_zero, hi, lo}, {3'b000, mdl_hi, mdl_lo});
    endtask

    vec_t tbl[8];

    initial begin
        logic [31:0] ra, rb;
        logic [1:0]  rop;
        int          pulses;

        tbl[0] = '{2'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        tbl[1] = '{2'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        tbl[2] = '{2'd2, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        tbl[3] = '{2'd3, 32'd100,        32'd7,         32'h0000_0002, 32'h0000_000E, 1'b0};
        tbl[4] = '{2'd3, 32'h64,         32'd0,         32'h0000_0064, 32'hFFFF_FFFF, 1'b1};
        tbl[5] = '{2'd2, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        tbl[6] = '{2'd2, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
        tbl[7] = '{2'd0, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};

        rst = 1'b1; start = 1'b0; op = 2'd0; a = '0; b = '0;
        we_hi = 1'b0; we_lo = 1'b0; wdata = '0;
        mdl_hi = '0; mdl_lo = '0;
        #3;
        check("reset_state", {busy, done, div_zero, hi, lo}, 67'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed table: expectations written out by hand, reference model cross-checked too
        for (int i = 0; i < 8; i++) begin
            check($sformatf("tbl%0d_model", i), {3'b0, ref_model(tbl[i].op, tbl[i].a, tbl[i].b)},
                  {3'b0, tbl[i].exp_dz, tbl[i].exp_hi, tbl[i].exp_lo});
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, 0, 1'b0, '0, $sformatf("tbl%0d", i));
            $display("vector tbl%0d op=%0d a=%h b=%h -> hi=%h lo=%h dz=%0b",
                     i, tbl[i].op, tbl[i].a, tbl[i].b, hi, lo, div_zero);
        end

        // Conflicting start/MTHI/MTLO mid-MULT are ignored
        run_op(2'd0, 32'd12345, 32'hFFFF_0001, 10, 1'b0, '0, "intf");
        $display("seq intf: hi=%h lo=%h", hi, lo);

        // MTLO, MTHI, and both together in IDLE
        we_lo = 1'b1; wdata = 32'h1234;
        @(posedge clk); #1;
        we_lo = 1'b0; mdl_lo = 32'h1234;
        check("mtlo", {hi, lo}, {mdl_hi, mdl_lo});
        we_hi = 1'b1; wdata = 32'hCAFE_0001;
        @(posedge clk); #1;
        we_hi = 1'b0; mdl_hi = 32'hCAFE_0001;
        check("mthi", {hi, lo}, {mdl_hi, mdl_lo});
        we_hi = 1'b1; we_lo = 1'b1; wdata = 32'h0BAD_F00D;
        @(posedge clk); #1;
        we_hi = 1'b0; we_lo = 1'b0; mdl_hi = 32'h0BAD_F00D; mdl_lo = 32'h0BAD_F00D;
        check("mthi_mtlo", {hi, lo}, {mdl_hi, mdl_lo});
        $display("seq writes: hi=%h lo=%h", hi, lo);

        // Write in the launch cycle, then overwritten by the op result
        run_op(2'd3, 32'd1000, 32'd33, 0, 1'b1, 32'h5A5A_5A5A, "wr_launch");
        $display("seq wr_launch: hi=%h lo=%h", hi, lo);

        // Asynchronous reset mid-CALC
        start = 1'b1; op = 2'd0; a = 32'd77; b = 32'd99;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_calc", {busy, done, div_zero, hi, lo}, 67'd0);
        #2 rst = 1'b0;
        mdl_hi = '0; mdl_lo = '0;
        pulses = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) pulses++;
        end
        check("no_done_after_rst", 68'(pulses), 68'd0);
        run_op(2'd1, 32'd77, 32'd99, 0, 1'b0, '0, "after_rst");
        $display("seq after_rst: hi=%h lo=%h", hi, lo);

        // Randomized ops, biased toward zero/small divisors and extreme operands
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom);
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = $urandom_range(1, 15);
                2: ra = 32'h8000_0000;
                3: rb = 32'hFFFF_FFFF;
                default: ;
            endcase
            run_op(rop, ra, rb, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, WIDTH)) : 0,
                   1'b0, '0, $sformatf("rnd%0d", i));
            $display("vector rnd%0d op=%0d a=%h b=%h -> hi=%h lo=%h dz=%0b",
                     i, rop, ra, rb, hi, lo, div_zero);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
